uart_apb_ctrl: RTL and testbench

UART_APB_CTRL -- requirements
Module: uart_apb_ctrl

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_apb_ctrl.sv | 178 +++++++++++++++++
 tb/tb_uart_apb_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART APB register block: register map,
// STATUS bit positions and the transfer FSM state type.
package uart_pkg;

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_DIV_LO = 8'h02;
  localparam logic [7:0] ADDR_DIV_HI = 8'h03;
  localparam logic [7:0] ADDR_CTRL   = 8'h04;

  localparam int STAT_RX_EMPTY = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_DONE     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RESP
  } ctrl_state_e;

  typedef enum logic [2:0] {
    SEL_DATA,
    SEL_STATUS,
    SEL_DIV_LO,
    SEL_DIV_HI,
    SEL_CTRL,
    SEL_NONE
  } reg_sel_e;

endpackage

// File: rtl/uart_apb_ctrl.sv
// APB slave front end for a UART: register decode, FIFO push/pop strobes,
// baud divisor storage and the transmit-done sticky flag.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for an access phase; decode + side effects here
// ST_RD_WAIT | RX FIFO popped, capturing its data_out into PRDATA
// ST_RESP    | PREADY high for one cycle
module uart_apb_ctrl
  import uart_pkg::*;
#(
  parameter int          D_W     = 8,
  parameter int          DIV_W   = 16,
  parameter int          APB_AW  = 8,
  parameter int unsigned DIV_RST = 54
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [APB_AW-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [D_W-1:0]    PWDATA,
  output logic              PREADY,
  output logic [D_W-1:0]    PRDATA,
  output logic              PSLVERR,
  output logic              rx_rd_en,
  input  logic [D_W-1:0]    rx_rdata,
  input  logic              rx_empty,
  input  logic              rx_full,
  output logic              tx_wr_en,
  output logic [D_W-1:0]    tx_wdata,
  input  logic              tx_full,
  input  logic              tx_empty,
  input  logic              tx_done,
  output logic [DIV_W-1:0]  divxr,
  output logic              tx_start
);

  localparam int HI_W = DIV_W - 8;

  ctrl_state_e      state, state_nxt;
  reg_sel_e         sel;
  logic             access;
  logic             done_sticky;
  logic             err;
  logic             clr_sticky;
  logic             div_wr;
  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] div_lo_cand;
  logic [DIV_W-1:0] div_hi_cand;
  logic [D_W-1:0]   rd_val;
  logic [D_W-1:0]   status_val;

  // Strobes are combinational on the decode cycle, so reset must gate them.
  assign access = (state == ST_IDLE) && PSEL && PENABLE && !rst;

  always_comb begin
    if (PADDR == APB_AW'(ADDR_DATA))        sel = SEL_DATA;
    else if (PADDR == APB_AW'(ADDR_STATUS)) sel = SEL_STATUS;
    else if (PADDR == APB_AW'(ADDR_DIV_LO)) sel = SEL_DIV_LO;
    else if (PADDR == APB_AW'(ADDR_DIV_HI)) sel = SEL_DIV_HI;
    else if (PADDR == APB_AW'(ADDR_CTRL))   sel = SEL_CTRL;
    else                                    sel = SEL_NONE;
  end

  // A tx_done landing on the decode cycle must be visible in that read.
  always_comb begin
    status_val                = '0;
    status_val[STAT_RX_EMPTY] = rx_empty;
    status_val[STAT_RX_FULL]  = rx_full;
    status_val[STAT_TX_EMPTY] = tx_empty;
    status_val[STAT_TX_FULL]  = tx_full;
    status_val[STAT_DONE]     = done_sticky | tx_done;
  end

  always_comb begin
    div_lo_cand            = divxr;
    div_lo_cand[7:0]       = 8'(PWDATA);
    div_hi_cand            = divxr;
    div_hi_cand[DIV_W-1:8] = HI_W'(PWDATA);
  end

  always_comb begin
    state_nxt  = state;
    rx_rd_en   = 1'b0;
    tx_wr_en   = 1'b0;
    tx_wdata   = '0;
    tx_start   = 1'b0;
    div_wr     = 1'b0;
    div_nxt    = divxr;
    rd_val     = '0;
    err        = 1'b0;
    clr_sticky = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          state_nxt = ST_RESP;
          case (sel)
            SEL_DATA: begin
              if (PWRITE) begin
                if (tx_full) begin
                  err = 1'b1;
                end else begin
                  tx_wr_en = 1'b1;
                  tx_wdata = PWDATA;
                end
              end else if (rx_empty) begin
                err = 1'b1;
              end else begin
                rx_rd_en  = 1'b1;
                state_nxt = ST_RD_WAIT;
              end
            end
            SEL_STATUS: begin
              if (PWRITE) begin
                err = 1'b1;
              end else begin
                rd_val     = status_val;
                clr_sticky = 1'b1;
              end
            end
            SEL_DIV_LO: begin
              if (!PWRITE) begin
                rd_val = D_W'(divxr[7:0]);
              end else if (div_lo_cand == '0) begin
                err = 1'b1;
              end else begin
                div_wr  = 1'b1;
                div_nxt = div_lo_cand;
              end
            end
            SEL_DIV_HI: begin
              if (!PWRITE) begin
                rd_val = D_W'(divxr[DIV_W-1:8]);
              end else if (div_hi_cand == '0) begin
                err = 1'b1;
              end else begin
                div_wr  = 1'b1;
                div_nxt = div_hi_cand;
              end
            end
            SEL_CTRL: begin
              if (PWRITE) tx_start = PWDATA[0];
            end
            default: err = 1'b1;
          endcase
        end
      end
      ST_RD_WAIT: state_nxt = PSEL ? ST_RESP : ST_IDLE;
      ST_RESP:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      PREADY      <= 1'b0;
      PSLVERR     <= 1'b0;
      PRDATA      <= '0;
      divxr       <= DIV_W'(DIV_RST);
      done_sticky <= 1'b0;
    end else begin
      state  <= state_nxt;
      PREADY <= (state_nxt == ST_RESP);
      if (access) begin
        PSLVERR <= err;
        PRDATA  <= rd_val;
      end
      if (state == ST_RD_WAIT) PRDATA <= rx_rdata;
      if (div_wr) divxr <= div_nxt;
      if (tx_done)         done_sticky <= 1'b1;
      else if (clr_sticky) done_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Randomized APB traffic against uart_apb_ctrl, checked by a register-map
// level reference model held in the bench.
module tb_uart_apb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PWDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  PRDATA;
  logic        rx_rd_en, rx_empty, rx_full;
  logic [7:0]  rx_rdata;
  logic        tx_wr_en, tx_full, tx_empty, tx_done, tx_start;
  logic [7:0]  tx_wdata;
  logic [15:0] divxr;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [7:0]  rx_q[$];
  logic [15:0] div_m;
  logic        sticky_m;

  uart_apb_ctrl #(.D_W(8), .DIV_W(16), .APB_AW(8), .DIV_RST(54)) dut (
    .clk(clk), .rst(rst),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .rx_rd_en(rx_rd_en), .rx_rdata(rx_rdata), .rx_empty(rx_empty), .rx_full(rx_full),
    .tx_wr_en(tx_wr_en), .tx_wdata(tx_wdata), .tx_full(tx_full), .tx_empty(tx_empty),
    .tx_done(tx_done), .divxr(divxr), .tx_start(tx_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One full APB transfer; the model predicts the outcome from the register map.
  task automatic apb_xfer(input logic [7:0] addr, input logic wr,
                          input logic [7:0] wdata, input logic done_pulse);
    logic [7:0]  exp_rdata, status_now, obs_rdata, pushed, pop_val;
    logic [15:0] cand;
    logic        exp_err, obs_err, got_ready, pop_now;
    int          exp_lat, exp_push, exp_pop, exp_start;
    int          n_push, n_pop, n_start, lat;
    rx_empty   = (rx_q.size() == 0);
    status_now = {3'b000, sticky_m | done_pulse, tx_full, tx_empty, rx_full, rx_empty};
    exp_err = 1'b0; exp_rdata = 8'h00; exp_lat = 1;
    exp_push = 0; exp_pop = 0; exp_start = 0; pop_val = 8'h00;
    case (addr)
      8'h00: begin
        if (wr) begin
          if (tx_full) exp_err = 1'b1;
          else exp_push = 1;
        end else if (rx_empty) begin
          exp_err = 1'b1;
        end else begin
          exp_pop = 1; exp_lat = 2;
          pop_val = rx_q.pop_front();
          exp_rdata = pop_val;
        end
      end
      8'h01: if (wr) exp_err = 1'b1; else exp_rdata = status_now;
      8'h02: begin
        if (wr) begin
          cand = {div_m[15:8], wdata};
          if (cand == 16'h0) exp_err = 1'b1; else div_m = cand;
        end else exp_rdata = div_m[7:0];
      end
      8'h03: begin
        if (wr) begin
          cand = {wdata, div_m[7:0]};
          if (cand == 16'h0) exp_err = 1'b1; else div_m = cand;
        end else exp_rdata = div_m[15:8];
      end
      8'h04: if (wr) exp_start = int'(wdata[0]);
      default: exp_err = 1'b1;
    endcase
    if (done_pulse) sticky_m = 1'b1;
    else if (addr == 8'h01 && !wr) sticky_m = 1'b0;

    @(posedge clk); #1;
    PADDR = addr; PWRITE = wr; PWDATA = wdata; PSEL = 1'b1; PENABLE = 1'b0;
    rx_rdata = 8'($urandom);
    @(posedge clk); #1;
    PENABLE = 1'b1; tx_done = done_pulse;
    n_push = 0; n_pop = 0; n_start = 0; lat = -1; got_ready = 1'b0;
    pushed = 8'h00; obs_err = 1'b0; obs_rdata = 8'h00;
    for (int c = 0; c < 6 && !got_ready; c++) begin
      @(negedge clk);
      pop_now = rx_rd_en;
      if (tx_wr_en) begin n_push++; pushed = tx_wdata; end
      if (rx_rd_en) n_pop++;
      if (tx_start) n_start++;
      if (PREADY) begin
        got_ready = 1'b1; lat = c; obs_err = PSLVERR; obs_rdata = PRDATA;
      end
      @(posedge clk); #1;
      tx_done  = 1'b0;
      rx_rdata = pop_now ? pop_val : 8'($urandom);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    if (tx_wr_en) n_push++;
    if (rx_rd_en) n_pop++;
    if (tx_start) n_start++;
    chk("ready_seen", got_ready, 1);
    chk("latency", lat, exp_lat);
    chk("pslverr", obs_err, exp_err);
    chk("prdata", obs_rdata, exp_rdata);
    chk("ready_after_resp", PREADY, 0);
    chk("prdata_hold", PRDATA, exp_rdata);
    chk("pslverr_hold", PSLVERR, exp_err);
    chk("push_count", n_push, exp_push);
    if (exp_push == 1) chk("tx_wdata", pushed, wdata);
    chk("pop_count", n_pop, exp_pop);
    chk("start_count", n_start, exp_start);
    chk("divxr", divxr, div_m);
  endtask

  initial begin
    rst = 1'b1; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h00;
    PWDATA = 8'hAA; rx_rdata = 8'h00; rx_empty = 1'b0; rx_full = 1'b0;
    tx_full = 1'b0; tx_empty = 1'b1; tx_done = 1'b0;
    div_m = 16'd54; sticky_m = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", PREADY, 0);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_divxr", divxr, 16'd54);
    chk("rst_tx_wr_en", tx_wr_en, 0);
    chk("rst_tx_wdata", tx_wdata, 0);
    chk("rst_rx_rd_en", rx_rd_en, 0);
    chk("rst_tx_start", tx_start, 0);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rx_empty = 1'b1;

    apb_xfer(8'h00, 1'b1, 8'h5A, 1'b0);
    rx_q.push_back(8'hC3);
    apb_xfer(8'h00, 1'b0, 8'h00, 1'b0);
    apb_xfer(8'h00, 1'b0, 8'h00, 1'b0);
    apb_xfer(8'h02, 1'b1, 8'h1B, 1'b0);
    apb_xfer(8'h03, 1'b1, 8'h00, 1'b0);
    chk("div_001b", divxr, 16'h001B);
    apb_xfer(8'h02, 1'b1, 8'h00, 1'b0);
    chk("div_zero_ignored", divxr, 16'h001B);
    apb_xfer(8'h01, 1'b0, 8'h00, 1'b1);
    apb_xfer(8'h01, 1'b0, 8'h00, 1'b0);
    apb_xfer(8'h01, 1'b0, 8'h00, 1'b0);
    apb_xfer(8'h04, 1'b1, 8'h01, 1'b0);
    apb_xfer(8'h04, 1'b0, 8'h00, 1'b0);
    tx_full = 1'b1;
    apb_xfer(8'h00, 1'b1, 8'h77, 1'b0);
    tx_full = 1'b0;
    apb_xfer(8'h01, 1'b1, 8'hFF, 1'b0);
    apb_xfer(8'h09, 1'b0, 8'h00, 1'b0);

    // PSEL withdrawn while waiting for RX data: no response, pop stands.
    rx_q.push_back(8'hA5); rx_empty = 1'b0;
    @(posedge clk); #1;
    PADDR = 8'h00; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    chk("drop_pop", rx_rd_en, 1);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; rx_rdata = rx_q.pop_front();
    @(negedge clk);
    chk("drop_rdwait_ready", PREADY, 0);
    @(negedge clk);
    chk("drop_idle_ready", PREADY, 0);
    chk("drop_no_repop", rx_rd_en, 0);

    // Reset while in the read wait state.
    rx_q.push_back(8'h3C); rx_empty = 1'b0;
    @(posedge clk); #1;
    PADDR = 8'h00; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; rx_rdata = rx_q.pop_front();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdwait_rst_pready", PREADY, 0);
    chk("rdwait_rst_divxr", divxr, 16'd54);
    chk("rdwait_rst_prdata", PRDATA, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    div_m = 16'd54; sticky_m = 1'b0;

    for (int i = 0; i < 200; i++) begin
      logic [7:0] a, d;
      tx_full  = ($urandom_range(0, 3) == 0);
      tx_empty = 1'($urandom);
      rx_full  = 1'($urandom);
      if (rx_q.size() < 4 && $urandom_range(0, 1) == 1) rx_q.push_back(8'($urandom));
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      apb_xfer(a, 1'($urandom), d, ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
